// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the default word/address widths, the arbiter FSM state encoding
// and the owner encoding used by the top and the round-robin picker.
package mem_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin picker.
// Ports:
//   i_req, d_req  - pending requests from the I and D sides
//   last_owner    - side that completed the previous access (1 = D, 0 = I)
//   grant_valid   - at least one side is requesting
//   grant_d       - winner is D (only meaningful when grant_valid = 1)
module rr_arbiter_2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_d
);

    assign grant_valid = i_req | d_req;

    // A lone requester always wins; on a tie the side that did not go last wins.
    assign grant_d = d_req & (~i_req | ~last_owner);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch side (I) and
// the data side (D). One request per side, round-robin on ties; the winner's
// command is held on the memory strobes for LATENCY cycles, then a one-cycle
// done pulse is returned to the owner together with captured read data.
// Ports:
//   clk, reset                       - clock, async active-high reset
//   i_req/i_we/i_addr/i_wdata        - I-side request (held until i_done)
//   i_rdata/i_done                   - I-side read data and completion pulse
//   d_*                              - same set for the D side
//   m_read/m_write/m_addr/m_wdata    - memory command
//   m_rdata                          - memory read data
//   busy                             - access in progress (ACCESS or DONE)
//   grant_d                          - current/last owner, 1 = D
module mem_port_arbiter #(
    parameter int WORD_SIZE  = mem_pkg::WORD_SIZE,
    parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_SIZE-1:0]  i_wdata,
    output logic [WORD_SIZE-1:0]  i_rdata,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic [WORD_SIZE-1:0]  d_rdata,
    output logic                  d_done,
    output logic                  m_read,
    output logic                  m_write,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WORD_SIZE-1:0]  m_wdata,
    input  logic [WORD_SIZE-1:0]  m_rdata,
    output logic                  busy,
    output logic                  grant_d
);

    import mem_pkg::*;

    // Counter only ever counts down from LATENCY-1 to 0, so it never wraps.
    localparam int              CW       = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    owner_t                  r_owner;
    owner_t                  r_last_owner;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WORD_SIZE-1:0]    r_wdata;
    logic [WORD_SIZE-1:0]    r_i_rdata;
    logic [WORD_SIZE-1:0]    r_d_rdata;
    logic [CW-1:0]           r_cnt;
    logic                    w_grant_valid;
    logic                    w_grant_d;
    logic                    w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    rr_arbiter_2 u_rr (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner == OWN_D),
        .grant_valid (w_grant_valid),
        .grant_d     (w_grant_d)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and strobes. Strobes decode straight from the state register
    // so an async reset drops them in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        m_read      = 1'b0;
        m_write     = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) w_state_nxt = ACCESS;
            end
            ACCESS: begin
                m_read  = ~r_we;
                m_write = r_we;
                if (w_cnt_zero) w_state_nxt = DONE;
            end
            DONE: begin
                i_done      = (r_owner == OWN_I);
                d_done      = (r_owner == OWN_D);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch, latency counter, read-data capture, round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_d ? OWN_D : OWN_I;
                        r_we    <= w_grant_d ? d_we    : i_we;
                        r_addr  <= w_grant_d ? d_addr  : i_addr;
                        r_wdata <= w_grant_d ? d_wdata : i_wdata;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (w_cnt_zero) begin
                        // Only the owner's read register changes; writes leave both alone.
                        if (!r_we) begin
                            if (r_owner == OWN_D) r_d_rdata <= m_rdata;
                            else                  r_i_rdata <= m_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_last_owner <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != IDLE);
    assign grant_d = (r_owner == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: three instances (LATENCY 2, 1, 4),
// each with its own behavioural memory, a transaction-level reference model
// compared every cycle, and directed sequences with literal expectations.
module tb_mem_port_arbiter;

    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 1, 4};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]       i_req = '0, i_we = '0, d_req = '0, d_we = '0;
    logic [NI-1:0][15:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [NI-1:0][15:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [NI-1:0]       i_done, d_done, m_read, m_write, busy, grant_d;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h23) ? 16'h6000 : {a, ~a};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [15:0]  mem [256];
        logic [255:0] wr = '0;

        mem_port_arbiter #(.WORD_SIZE(16), .ADDR_WIDTH(16), .LATENCY(LATS[g])) u_dut (
            .clk     (clk),
            .reset   (reset),
            .i_req   (i_req[g]),
            .i_we    (i_we[g]),
            .i_addr  (i_addr[g]),
            .i_wdata (i_wdata[g]),
            .i_rdata (i_rdata[g]),
            .i_done  (i_done[g]),
            .d_req   (d_req[g]),
            .d_we    (d_we[g]),
            .d_addr  (d_addr[g]),
            .d_wdata (d_wdata[g]),
            .d_rdata (d_rdata[g]),
            .d_done  (d_done[g]),
            .m_read  (m_read[g]),
            .m_write (m_write[g]),
            .m_addr  (m_addr[g]),
            .m_wdata (m_wdata[g]),
            .m_rdata (m_rdata[g]),
            .busy    (busy[g]),
            .grant_d (grant_d[g])
        );

        always @(posedge clk) begin
            if (m_write[g]) begin
                mem[m_addr[g][7:0]] <= m_wdata[g];
                wr[m_addr[g][7:0]]  <= 1'b1;
            end
        end
        assign m_rdata[g] = wr[m_addr[g][7:0]] ? mem[m_addr[g][7:0]] : init_val(m_addr[g][7:0]);
    end

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, n, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: a granted access occupies phases 1..L on the strobes
    // and phase L+1 is the done cycle; phase counting starts at the grant.
    logic [NI-1:0]       md_act, md_own, md_we, md_last, md_grant;
    int                  md_p [NI];
    logic [NI-1:0][15:0] md_a, md_wd, md_ri, md_rd;
    logic [15:0]         ref_mem [NI][256];
    logic [NI-1:0][255:0] ref_wr = '0;

    function automatic logic [15:0] ref_rd(input int n, input logic [7:0] a);
        return ref_wr[n][a] ? ref_mem[n][a] : init_val(a);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int n = 0; n < NI; n++) begin
                int   L;
                logic stb, dn;
                L = LATS[n];
                if (reset) begin
                    md_act[n] = 1'b0; md_p[n] = 0; md_own[n] = 1'b0; md_we[n] = 1'b0;
                    md_last[n] = 1'b0; md_grant[n] = 1'b0;
                    md_a[n] = '0; md_wd[n] = '0; md_ri[n] = '0; md_rd[n] = '0;
                end
                stb = md_act[n] && md_p[n] >= 1 && md_p[n] <= L;
                dn  = md_act[n] && md_p[n] == L + 1;
                chk("m_read",  n, 32'(m_read[n]),  32'(stb && !md_we[n]));
                chk("m_write", n, 32'(m_write[n]), 32'(stb && md_we[n]));
                chk("m_addr",  n, 32'(m_addr[n]),  32'(md_a[n]));
                chk("m_wdata", n, 32'(m_wdata[n]), 32'(md_wd[n]));
                chk("i_done",  n, 32'(i_done[n]),  32'(dn && !md_own[n]));
                chk("d_done",  n, 32'(d_done[n]),  32'(dn && md_own[n]));
                chk("i_rdata", n, 32'(i_rdata[n]), 32'(md_ri[n]));
                chk("d_rdata", n, 32'(d_rdata[n]), 32'(md_rd[n]));
                chk("busy",    n, 32'(busy[n]),    32'(md_act[n]));
                chk("grant_d", n, 32'(grant_d[n]), 32'(md_grant[n]));
                if (!reset) begin
                    if (!md_act[n]) begin
                        if (i_req[n] || d_req[n]) begin
                            md_own[n]   = (i_req[n] && d_req[n]) ? !md_last[n] : d_req[n];
                            md_we[n]    = md_own[n] ? d_we[n]    : i_we[n];
                            md_a[n]     = md_own[n] ? d_addr[n]  : i_addr[n];
                            md_wd[n]    = md_own[n] ? d_wdata[n] : i_wdata[n];
                            md_grant[n] = md_own[n];
                            md_act[n]   = 1'b1;
                            md_p[n]     = 1;
                        end
                    end else if (md_p[n] == L) begin
                        if (md_we[n]) begin
                            ref_mem[n][md_a[n][7:0]] = md_wd[n];
                            ref_wr[n][md_a[n][7:0]]  = 1'b1;
                        end else if (md_own[n]) begin
                            md_rd[n] = ref_rd(n, md_a[n][7:0]);
                        end else begin
                            md_ri[n] = ref_rd(n, md_a[n][7:0]);
                        end
                        md_p[n]++;
                    end else if (md_p[n] == L + 1) begin
                        md_last[n] = md_own[n];
                        md_act[n]  = 1'b0;
                        md_p[n]    = 0;
                    end else begin
                        md_p[n]++;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input bit side, input bit we, input logic [15:0] a,
                           input logic [15:0] wd);
        if (side) begin
            d_we[n] = we; d_addr[n] = a; d_wdata[n] = wd; d_req[n] = 1'b1;
        end else begin
            i_we[n] = we; i_addr[n] = a; i_wdata[n] = wd; i_req[n] = 1'b1;
        end
    endtask

    // Cycle index 0 is the cycle in which this is called.
    task automatic wait_done(input int n, input bit side, input int exp_cyc, input int exp_stb);
        int cyc = -1;
        int stb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (side ? d_done[n] : i_done[n]) begin
                cyc = c;
                break;
            end
            if (m_read[n] | m_write[n]) stb++;
        end
        chk("done_cycle",   n, 32'(cyc), 32'(exp_cyc));
        chk("strobe_width", n, 32'(stb), 32'(exp_stb));
    endtask

    initial begin
        int t_done [4];
        int o_done [4];
        int k;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_done [4];
        int o_done [4];
        int k;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Single I read of 0x23.
        step();
        set_req(0, 0, 0, 16'h0023, 16'h0);
        wait_done(0, 0, 3, 2);
        chk("i_rdata_lit", 0, 32'(i_rdata[0]), 32'h6000);
        step();
        i_req[0] = 1'b0;
        @(negedge clk);
        chk("busy_after", 0, 32'(busy[0]), 32'h0);

        // D write 0x10 <- 0xABCD, then read it back.
        step();
        set_req(0, 1, 1, 16'h0010, 16'hABCD);
        wait_done(0, 1, 3, 2);
        chk("d_rdata_kept", 0, 32'(d_rdata[0]), 32'h0);
        step();
        d_req[0] = 1'b0;
        step();
        set_req(0, 1, 0, 16'h0010, 16'h0);
        wait_done(0, 1, 3, 2);
        chk("d_rdata_lit", 0, 32'(d_rdata[0]), 32'hABCD);
        step();
        d_req[0] = 1'b0;

        // Both sides held from reset: D, I, D, I, every 4 cycles.
        step();
        reset = 1'b1;
        set_req(0, 0, 0, 16'h0023, 16'h0);
        set_req(0, 1, 0, 16'h0010, 16'h0);
        step();
        step();
        reset = 1'b0;
        k = 0;
        for (int j = 0; j < 4; j++) begin t_done[j] = -1; o_done[j] = -1; end
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            chk("dual_done", 0, 32'(i_done[0] & d_done[0]), 32'h0);
            if (i_done[0] | d_done[0]) begin
                t_done[k] = c;
                o_done[k] = int'(d_done[0]);
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            chk("grant_order", 0, 32'(o_done[j]), 32'((j % 2) == 0));
            chk("done_time",   0, 32'(t_done[j]), 32'(3 + 4 * j));
        end
        step();
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;

        // Tie goes to D (last was I); D withdraws mid-access, I is served next.
        step();
        set_req(0, 1, 0, 16'h0023, 16'h0);
        set_req(0, 0, 0, 16'h0010, 16'h0);
        step();
        d_req[0] = 1'b0;
        wait_done(0, 1, 2, 2);
        chk("d_rdata_wd", 0, 32'(d_rdata[0]), 32'h6000);
        wait_done(0, 0, 3, 2);
        chk("i_rdata_wd", 0, 32'(i_rdata[0]), 32'hABCD);
        step();
        i_req[0] = 1'b0;

        // Reset in the first ACCESS cycle aborts; request restarts afterwards.
        step();
        set_req(0, 0, 0, 16'h0023, 16'h0);
        step();
        chk("m_read_pre_rst", 0, 32'(m_read[0]), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("m_read_rst", 0, 32'(m_read[0]), 32'h0);
        chk("busy_rst",   0, 32'(busy[0]),   32'h0);
        step();
        chk("i_done_rst", 0, 32'(i_done[0]), 32'h0);
        chk("i_rdata_rst", 0, 32'(i_rdata[0]), 32'h0);
        step();
        reset = 1'b0;
        wait_done(0, 0, 3, 2);
        chk("i_rdata_restart", 0, 32'(i_rdata[0]), 32'h6000);
        step();
        i_req[0] = 1'b0;

        // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
        for (int n = 1; n < NI; n++) begin
            step();
            set_req(n, 0, 0, 16'h0023, 16'h0);
            wait_done(n, 0, LATS[n] + 1, LATS[n]);
            chk("i_rdata_sweep", n, 32'(i_rdata[n]), 32'h6000);
            step();
            i_req[n] = 1'b0;
            step();
            set_req(n, 1, 1, 16'h0040, 16'h1234);
            wait_done(n, 1, LATS[n] + 1, LATS[n]);
            step();
            d_req[n] = 1'b0;
            step();
            set_req(n, 1, 0, 16'h0040, 16'h0);
            wait_done(n, 1, LATS[n] + 1, LATS[n]);
            chk("d_rdata_sweep", n, 32'(d_rdata[n]), 32'h1234);
            step();
            d_req[n] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the instruction-fetch side (I) and the data-access side (D).
- Accepts one request per side, picks a winner by two-way round-robin, and drives the memory read/write strobes, address and write data for the fixed memory access latency.
- Returns read data and a one-cycle done pulse to the owner.
- Sits between the CPU/cache front ends and the memory model, replacing direct per-side memory strobing.

Parameters:
- WORD_SIZE, 16, data word width in bits.
- ADDR_WIDTH, 16, address width in bits.
- LATENCY, 2, cycles the memory command is held before read data is valid; legal values >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  I-side request; held until i_done.
- i_we  in  1  I-side write enable; 0 = read.
- i_addr  in  ADDR_WIDTH  I-side word address.
- i_wdata  in  WORD_SIZE  I-side write data.
- i_rdata  out  WORD_SIZE  I-side read data; valid when i_done = 1.
- i_done  out  1  one-cycle completion pulse for I.
- d_req, d_we, d_addr, d_wdata, d_rdata, d_done  same as the I-side ports, for D.
- m_read  out  1  memory read strobe.
- m_write  out  1  memory write strobe.
- m_addr  out  ADDR_WIDTH  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data.
- busy  out  1  high in ACCESS and DONE.
- grant_d  out  1  current/last owner; 1 = D, 0 = I.

Behaviour:
- Reset (async, active-high), forced immediately regardless of state:
  - state = IDLE, counter = 0, last_owner = I.
  - All outputs = 0.
  - A reset mid-access drops m_read/m_write immediately; no done pulse is issued for the aborted access.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; m_read = m_write = 0.
  - Exactly one req high: that side wins.
  - Both high: the side that is not last_owner wins. After reset the first tie goes to D.
  - On the granting edge:
    - Latch owner, we, addr and wdata from the winner.
    - Set grant_d = owner.
    - Set counter = LATENCY-1.
    - Go to ACCESS.
- ACCESS:
  - m_read = !we_latched, m_write = we_latched, held for exactly LATENCY cycles.
  - m_addr and m_wdata are stable from the latched values.
  - Counter decrements each cycle.
  - On the cycle counter = 0:
    - For reads, capture m_rdata into the owner's rdata register (the other side's rdata register is unchanged).
    - Go to DONE.
- DONE (one cycle):
  - m_read = m_write = 0.
  - Owner's done = 1.
  - last_owner <= owner.
  - Go to IDLE.
  - Writes leave rdata unchanged.
- Latency: req first sampled in IDLE cycle 0 → ACCESS cycles 1..LATENCY → done in cycle LATENCY+1.
- Requester rules:
  - Keep req high until the done pulse is observed, then drop it.
  - req still high in the following IDLE cycle is a new request.
  - Addr/we/wdata changes after grant are ignored.
- Request withdrawn mid-ACCESS: the access still completes and done still pulses.
- The losing side's req stays pending and is granted in the next IDLE.
  - With both sides continuously requesting, grants strictly alternate: no starvation, at most one waiting transaction.
- i_done and d_done are never high in the same cycle.
- m_read and m_write are never high in the same cycle.
- Counter width is clog2(LATENCY)+1; it never wraps.

Decomposition:
- Shared package mem_pkg holds:
  - WORD_SIZE and ADDR_WIDTH constants.
  - State enum {IDLE, ACCESS, DONE}.
  - Owner enum {OWN_I, OWN_D}.
- One sub-module, rr_arbiter_2: combinational two-way round-robin picker with inputs i_req, d_req, last_owner and outputs grant_valid, grant_d.

Test Plan:
- Single I read, LATENCY=2, mem[0x23]=0x6000, i_req at cycle 0 → m_read high cycles 1-2 with m_addr=0x23; i_done and i_rdata=0x6000 in cycle 3; busy low in cycle 4.
- Single D write of addr 0x10, data 0xABCD → m_write high for exactly 2 cycles with stable addr/data; d_done one cycle; d_rdata unchanged; a following D read of 0x10 returns 0xABCD.
- Both sides requesting from reset and held continuously → grant order D, I, D, I; each done appears LATENCY+2 cycles apart; never two dones in one cycle.
- Reset asserted mid-ACCESS (cycle 1 of 2) → m_read drops same cycle; no done pulses; after release the pending request restarts from IDLE and completes normally.
- d_req dropped during ACCESS → access completes and d_done still pulses; next IDLE grants the pending I.
- Parameter sweep LATENCY=1 and LATENCY=4 → strobe width equals LATENCY; done appears at cycle LATENCY+1.
